// File: rtl/waveform_uart_packer.sv
// -----------------------------------------------------------------------------
// waveform_uart_packer
//
// Sits after the ADC capture stage. On the falling edge of long_trigger it
// snapshots the waveform and pulse height into shadow registers. It then
// streams them as a framed byte packet over a valid/ready byte interface to
// the UART transmitter. Triggers that arrive while a packet is in flight are
// dropped and counted.
//
// Frame layout, with every multi-byte field sent MSB first:
//   SYNC0, SYNC1, seq, pulse_height[31:0], then for each sample
//   {hi, lo} of the zero-extended 16-bit sample, then optionally a checksum.
//
// Build option:
//   PACKER_CHECKSUM_EN - append one checksum byte. It is the XOR of every
//                        byte from seq through the last sample lo byte.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   long_trigger  capture-window flag; capture on its 1->0 edge
//   waveform      captured samples, index 0 sent first
//   pulse_height  pulse height from the capture stage
//   tx_data       byte to the UART transmitter
//   tx_valid      tx_data holds a byte
//   tx_ready      transmitter accepts the byte this cycle
//   busy          packet in flight
//   dropped_count saturating count of triggers lost while busy
// -----------------------------------------------------------------------------
module waveform_uart_packer #(
    parameter int         SAMPLES  = 32,
    parameter int         SAMPLE_W = 14,
    parameter logic [7:0] SYNC0    = 8'hA5,
    parameter logic [7:0] SYNC1    = 8'h5A
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               long_trigger,
    input  logic [SAMPLES-1:0][SAMPLE_W-1:0]   waveform,
    input  logic [31:0]                        pulse_height,
    output logic [7:0]                         tx_data,
    output logic                               tx_valid,
    input  logic                               tx_ready,
    output logic                               busy,
    output logic [15:0]                        dropped_count
);

    // The byte index must cover both the 4 height bytes and the 2*SAMPLES
    // sample bytes.
    localparam int IDX_W = (2 * SAMPLES > 4) ? $clog2(2 * SAMPLES) : 2;
    localparam logic [IDX_W-1:0] LAST_SAMPLE_IDX = IDX_W'(2 * SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_HEIGHT,
        S_SAMPLES
`ifdef PACKER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    state_t                             state;
    state_t                             next_state;
    logic [IDX_W-1:0]                   byte_idx;
    logic [IDX_W-1:0]                   next_idx;
    logic [IDX_W-2:0]                   sample_sel;
    logic [15:0]                        sample_word;
    logic [7:0]                         next_byte;
    logic                               last_xfer;
    logic                               lt_d;
    logic                               capture;
    logic                               xfer;
    logic [7:0]                         seq;
    logic [SAMPLES-1:0][SAMPLE_W-1:0]   shadow_wave;
    logic [31:0]                        shadow_ph;
`ifdef PACKER_CHECKSUM_EN
    logic [7:0]                         csum;
`endif

    assign capture = lt_d & ~long_trigger;
    assign xfer    = tx_valid & tx_ready;
    assign busy    = (state != S_IDLE);

    // Work out the frame position that follows the byte currently on tx_data.
    // This position only takes effect when the current byte is transferred.
    always_comb begin
        next_state = state;
        next_idx   = byte_idx;
        last_xfer  = 1'b0;
        case (state)
            S_SYNC: begin
                if (byte_idx == IDX_W'(1)) begin
                    next_state = S_SEQ;
                    next_idx   = '0;
                end else begin
                    next_idx = byte_idx + IDX_W'(1);
                end
            end
            S_SEQ: begin
                next_state = S_HEIGHT;
                next_idx   = '0;
            end
            S_HEIGHT: begin
                if (byte_idx == IDX_W'(3)) begin
                    next_state = S_SAMPLES;
                    next_idx   = '0;
                end else begin
                    next_idx = byte_idx + IDX_W'(1);
                end
            end
            S_SAMPLES: begin
                if (byte_idx == LAST_SAMPLE_IDX) begin
`ifdef PACKER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_IDLE;
                    last_xfer  = 1'b1;
`endif
                    next_idx = '0;
                end else begin
                    next_idx = byte_idx + IDX_W'(1);
                end
            end
`ifdef PACKER_CHECKSUM_EN
            S_CSUM: begin
                next_state = S_IDLE;
                next_idx   = '0;
                last_xfer  = 1'b1;
            end
`endif
            default: begin
                next_state = S_IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // Choose the byte for the next frame position. The sample index is the
    // byte index halved, and the even byte index is the hi byte. The checksum
    // folds in the outgoing lo byte, because the running XOR has not absorbed
    // that byte yet.
    always_comb begin
        sample_sel  = next_idx[IDX_W-1:1];
        sample_word = '0;
        sample_word[SAMPLE_W-1:0] = shadow_wave[sample_sel];
        next_byte   = 8'h00;
        case (next_state)
            S_SYNC:    next_byte = (next_idx == '0) ? SYNC0 : SYNC1;
            S_SEQ:     next_byte = seq;
            S_HEIGHT: begin
                case (next_idx[1:0])
                    2'd0:    next_byte = shadow_ph[31:24];
                    2'd1:    next_byte = shadow_ph[23:16];
                    2'd2:    next_byte = shadow_ph[15:8];
                    default: next_byte = shadow_ph[7:0];
                endcase
            end
            S_SAMPLES: next_byte = next_idx[0] ? sample_word[7:0] : sample_word[15:8];
`ifdef PACKER_CHECKSUM_EN
            S_CSUM:    next_byte = csum ^ tx_data;
`endif
            default:   next_byte = 8'h00;
        endcase
    end

    // Packet sequencer with registered tx outputs. A capture is taken only in
    // IDLE. A trigger edge seen in any other state, including the final
    // transfer cycle, is counted as dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            byte_idx      <= '0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            seq           <= 8'h00;
            dropped_count <= 16'h0000;
            lt_d          <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
            csum          <= 8'h00;
`endif
        end else begin
            lt_d <= long_trigger;
            if (capture && (state != S_IDLE) && (dropped_count != 16'hFFFF)) begin
                dropped_count <= dropped_count + 16'd1;
            end
            if (state == S_IDLE) begin
                if (capture) begin
                    state    <= S_SYNC;
                    byte_idx <= '0;
                    tx_data  <= SYNC0;
                    tx_valid <= 1'b1;
`ifdef PACKER_CHECKSUM_EN
                    csum     <= 8'h00;
`endif
                end
            end else if (xfer) begin
                state    <= next_state;
                byte_idx <= next_idx;
                tx_data  <= next_byte;
                tx_valid <= ~last_xfer;
                if (last_xfer) begin
                    seq <= seq + 8'd1;
                end
`ifdef PACKER_CHECKSUM_EN
                if ((state == S_SEQ) || (state == S_HEIGHT) || (state == S_SAMPLES)) begin
                    csum <= csum ^ tx_data;
                end
`endif
            end
        end
    end

    // The shadow copy holds the snapshot steady while the inputs move on.
    // It is always reloaded before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture && (state == S_IDLE)) begin
            shadow_wave <= waveform;
            shadow_ph   <= pulse_height;
        end
    end

endmodule

// File: tb/tb_waveform_uart_packer.sv
module tb_waveform_uart_packer;

    localparam int SAMPLES  = 32;
    localparam int SAMPLE_W = 14;
`ifdef PACKER_CHECKSUM_EN
    localparam int FRAME_LEN = 8 + 2 * SAMPLES;
    localparam bit HAS_CSUM  = 1'b1;
`else
    localparam int FRAME_LEN = 7 + 2 * SAMPLES;
    localparam bit HAS_CSUM  = 1'b0;
`endif

    logic                             clk = 1'b0;
    logic                             reset_n;
    logic                             long_trigger;
    logic [SAMPLES-1:0][SAMPLE_W-1:0] waveform;
    logic [31:0]                      pulse_height;
    logic [7:0]                       tx_data;
    logic                             tx_valid;
    logic                             tx_ready;
    logic                             busy;
    logic [15:0]                      dropped_count;

    waveform_uart_packer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .long_trigger  (long_trigger),
        .waveform      (waveform),
        .pulse_height  (pulse_height),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ready_pct;
        int          trig_a;
        int          trig_b;
        int          wave_mode;
        logic [31:0] ph;
        int          exp_drops;
        int          exp_len;
    } vec_t;

    vec_t        vec_tab[6];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  model_seq;
    logic [15:0] model_drop;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    // Generic scalar comparison.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-frame content comparison; reports the first differing byte.
    task automatic checkFrame(input string name);
        int bad = -1;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL %s byte %0d: got %02h expected %02h", name, bad, got_q[bad], exp_q[bad]);
        end
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
        int s = int'(a) + n;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // Reference frame straight from the packet layout.
    task automatic buildExpected();
        logic [7:0]  x;
        logic [15:0] word;
        exp_q = {};
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(model_seq);
        for (int k = 3; k >= 0; k--) exp_q.push_back(pulse_height[8*k +: 8]);
        for (int i = 0; i < SAMPLES; i++) begin
            word = 16'(waveform[i]);
            exp_q.push_back(word[15:8]);
            exp_q.push_back(word[7:0]);
        end
        if (HAS_CSUM) begin
            x = 8'h00;
            for (int k = 2; k < exp_q.size(); k++) x ^= exp_q[k];
            exp_q.push_back(x);
        end
    endtask

    task automatic fillWave(input int mode);
        for (int i = 0; i < SAMPLES; i++) begin
            case (mode)
                0:       waveform[i] = SAMPLE_W'(i);
                2:       waveform[i] = '1;
                default: waveform[i] = SAMPLE_W'($urandom);
            endcase
        end
    endtask

    task automatic fireTrigger();
        @(negedge clk) long_trigger = 1'b1;
        @(negedge clk) long_trigger = 1'b0;
    endtask

    // Consume one frame at the given ready duty. Raise long_trigger when the
    // transferred-byte count equals trig_a or trig_b. Check that stalled bytes
    // hold, and scramble the inputs once the capture has been taken.
    task automatic collect(input int ready_pct, input int trig_a, input int trig_b, output int cycles);
        bit         stall = 1'b0;
        logic [7:0] prev  = 8'h00;
        got_q  = {};
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                fillWave(1);
                pulse_height = $urandom;
            end
            if (cycles > 4000) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL frame_timeout: got %0d bytes expected end of frame", got_q.size());
                break;
            end
            if (!tx_valid) break;
            if (stall) checkOutput("stall_hold", tx_data, prev);
            long_trigger = (got_q.size() == trig_a) || (got_q.size() == trig_b);
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tx_ready) got_q.push_back(tx_data);
            stall = ~tx_ready;
            prev  = tx_data;
        end
        long_trigger = 1'b0;
        tx_ready     = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc;
        fillWave(v.wave_mode);
        pulse_height = v.ph;
        buildExpected();
        fireTrigger();
        collect(v.ready_pct, v.trig_a, v.trig_b, cyc);
        checkOutput({tag, "_len"}, got_q.size(), v.exp_len);
        checkFrame({tag, "_bytes"});
        if (v.ready_pct >= 100) checkOutput({tag, "_cycles"}, cyc, v.exp_len + 1);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
        model_seq  = model_seq + 8'd1;
        model_drop = sat_add(model_drop, v.exp_drops);
        checkOutput({tag, "_dropped"}, dropped_count, model_drop);
    endtask

    initial begin
        int   cyc;
        vec_t rnd;

        vec_tab[0] = '{100, -1, -1, 0, 32'h0000_1234, 0, FRAME_LEN};
        vec_tab[1] = '{30,  -1, -1, 0, 32'h0000_1234, 0, FRAME_LEN};
        vec_tab[2] = '{100, 20, FRAME_LEN - 2, 1, $urandom, 2, FRAME_LEN};
        vec_tab[3] = '{60,  -1, -1, 2, 32'hFFFF_FFFF, 0, FRAME_LEN};
        vec_tab[4] = '{100, -1, -1, 1, $urandom, 0, FRAME_LEN};
        vec_tab[5] = '{45,  -1, -1, 1, $urandom, 0, FRAME_LEN};

        reset_n      = 1'b1;
        long_trigger = 1'b0;
        tx_ready     = 1'b0;
        waveform     = '0;
        pulse_height = 32'h0;
        model_seq    = 8'h00;
        model_drop   = 16'h0000;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_valid", tx_valid, 1'b0);
        checkOutput("reset_tx_data", tx_data, 8'h00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_dropped", dropped_count, 16'h0000);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec_tab[i], $sformatf("vec%0d", i));
            if (i == 0 && got_q.size() > 0) begin
                checkOutput("test1_last_byte", got_q[got_q.size()-1], HAS_CSUM ? 8'h26 : 8'h1F);
            end
        end

        // Abort mid-packet with an asynchronous reset, holding long_trigger
        // high across the release.
        fillWave(1);
        pulse_height = $urandom;
        fireTrigger();
        tx_ready = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("busy_mid_frame", busy, 1'b1);
        #2 reset_n = 1'b0;
        long_trigger = 1'b1;
        #1;
        checkOutput("async_reset_valid", tx_valid, 1'b0);
        checkOutput("async_reset_busy", busy, 1'b0);
        checkOutput("async_reset_dropped", dropped_count, 16'h0000);
        tx_ready   = 1'b0;
        model_seq  = 8'h00;
        model_drop = 16'h0000;
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("held_high_no_capture_busy", busy, 1'b0);
        checkOutput("held_high_no_capture_valid", tx_valid, 1'b0);
        fillWave(1);
        pulse_height = $urandom;
        buildExpected();
        long_trigger = 1'b0;
        collect(100, -1, -1, cyc);
        checkOutput("post_reset_len", got_q.size(), FRAME_LEN);
        checkFrame("post_reset_bytes");
        if (got_q.size() > 2) checkOutput("post_reset_seq", got_q[2], 8'h00);
        model_seq = model_seq + 8'd1;

        // Back-to-back frames to walk seq through a full wrap.
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        model_seq  = 8'h00;
        model_drop = 16'h0000;
        for (int f = 0; f < 257; f++) begin
            rnd = '{100, -1, -1, 1, $urandom, 0, FRAME_LEN};
            applyStimulus(rnd, "wrap");
            if (f == 256 && got_q.size() > 2) checkOutput("seq_wrap", got_q[2], 8'h00);
            if (f == 255 && got_q.size() > 2) checkOutput("seq_ff", got_q[2], 8'hFF);
        end

        // Saturation: stall a packet, preload the counter near the top, then
        // drop more triggers than it can count.
        fillWave(1);
        pulse_height = $urandom;
        fireTrigger();
        @(negedge clk);
        checkOutput("sat_busy", busy, 1'b1);
        force dut.dropped_count = 16'hFFFD;
        @(negedge clk);
        release dut.dropped_count;
        model_drop = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) long_trigger = 1'b1;
            @(negedge clk) long_trigger = 1'b0;
            @(negedge clk);
            model_drop = sat_add(model_drop, 1);
            checkOutput($sformatf("sat_dropped%0d", k), dropped_count, model_drop);
        end
        checkOutput("sat_stall_valid", tx_valid, 1'b1);
        checkOutput("sat_stall_data", tx_data, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
